// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The slave side is the adder; the master side is its producer and consumer.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle through a ripple chain,
// then holds the result until the consumer takes it.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("serial_adder: CHUNK must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_csum;
  logic             w_cmsb;
  logic             w_cout;

  // Returns {carry out, carry into MSB, chunk sum} of a CHUNK-bit ripple chain.
  function automatic logic [CHUNK+1:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             ci);
    logic             c;
    logic             c_msb;
    logic [CHUNK-1:0] s;
    c     = ci;
    c_msb = ci;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, c_msb, s};
  endfunction

  assign w_ca = r_a[int'(r_cnt) * CHUNK +: CHUNK];
  assign w_cb = r_b[int'(r_cnt) * CHUNK +: CHUNK];
  assign {w_cout, w_cmsb, w_csum} = add_chunk(w_ca, w_cb, r_carry);

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == CW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is folded in at capture: B is inverted and the carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b ^ {WIDTH{bus.sub}};
      r_carry <= bus.sub | bus.cin;
      r_cnt   <= '0;
    end else if (r_state == BUSY) begin
      r_sum[int'(r_cnt) * CHUNK +: CHUNK] <= w_csum;
      r_carry <= w_cout;
      if (w_last) r_ovf <= w_cmsb ^ w_cout;
      else        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_carry;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder across several WIDTH/CHUNK configurations.
module tb_serial_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  // Per-DUT drive and observe slots: 0=W1/C1, 1=W8/C1, 2=W8/C4, 3=W16/C4, 4=W8/C8
  logic        iv[5], ors[5], ci[5], sb[5];
  logic [15:0] av[5], bv[5];
  logic        ir[5], ov[5], co[5], of[5];
  logic [15:0] sm[5];

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(1))  if0 ();
  serial_adder_if #(.WIDTH(8))  if1 ();
  serial_adder_if #(.WIDTH(8))  if2 ();
  serial_adder_if #(.WIDTH(16)) if3 ();
  serial_adder_if #(.WIDTH(8))  if4 ();

  serial_adder #(.WIDTH(1),  .CHUNK(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  serial_adder #(.WIDTH(8),  .CHUNK(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(8),  .CHUNK(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  serial_adder #(.WIDTH(16), .CHUNK(4)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  serial_adder #(.WIDTH(8),  .CHUNK(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  assign if0.in_valid = iv[0]; assign if0.out_ready = ors[0]; assign if0.cin = ci[0]; assign if0.sub = sb[0];
  assign if0.a = av[0][0:0];   assign if0.b = bv[0][0:0];
  assign ir[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign co[0] = if0.cout; assign of[0] = if0.ovf;
  assign sm[0] = 16'(if0.sum);

  assign if1.in_valid = iv[1]; assign if1.out_ready = ors[1]; assign if1.cin = ci[1]; assign if1.sub = sb[1];
  assign if1.a = av[1][7:0];   assign if1.b = bv[1][7:0];
  assign ir[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign co[1] = if1.cout; assign of[1] = if1.ovf;
  assign sm[1] = 16'(if1.sum);

  assign if2.in_valid = iv[2]; assign if2.out_ready = ors[2]; assign if2.cin = ci[2]; assign if2.sub = sb[2];
  assign if2.a = av[2][7:0];   assign if2.b = bv[2][7:0];
  assign ir[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign co[2] = if2.cout; assign of[2] = if2.ovf;
  assign sm[2] = 16'(if2.sum);

  assign if3.in_valid = iv[3]; assign if3.out_ready = ors[3]; assign if3.cin = ci[3]; assign if3.sub = sb[3];
  assign if3.a = av[3];        assign if3.b = bv[3];
  assign ir[3] = if3.in_ready; assign ov[3] = if3.out_valid; assign co[3] = if3.cout; assign of[3] = if3.ovf;
  assign sm[3] = if3.sum;

  assign if4.in_valid = iv[4]; assign if4.out_ready = ors[4]; assign if4.cin = ci[4]; assign if4.sub = sb[4];
  assign if4.a = av[4][7:0];   assign if4.b = bv[4][7:0];
  assign ir[4] = if4.in_ready; assign ov[4] = if4.out_valid; assign co[4] = if4.cout; assign of[4] = if4.ovf;
  assign sm[4] = 16'(if4.sum);

  function automatic int wd(input int d);
    case (d)
      0:       return 1;
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  // Reference: plain integer add of the WIDTH-bit operands; overflow from operand/result signs.
  function automatic exp_t model(input int d, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    int          w;
    logic [16:0] mask, aa, bb, full;
    w    = wd(d);
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & mask;
    bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = aa + bb + {16'd0, (sub ? 1'b1 : cin)};
    e.s  = full[15:0] & mask[15:0];
    e.c  = full[w];
    e.o  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Latency counts clock edges with the accept edge as edge 1.
  task automatic txn(input int d, input logic [15:0] a, input logic [15:0] b, input logic cin,
                     input logic sub, input int exp_lat, input int hold, input int pre);
    exp_t e;
    int   n;
    int   lat;
    repeat (pre) @(negedge clk);
    n = 0;
    while (!ir[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 32'(ir[d]), 32'd1);
    av[d] = a; bv[d] = b; ci[d] = cin; sb[d] = sub; iv[d] = 1'b1;
    sbq.push_back(model(d, a, b, cin, sub));
    @(negedge clk);
    iv[d] = 1'b0;
    av[d] = 16'($urandom); bv[d] = 16'($urandom); ci[d] = 1'($urandom); sb[d] = 1'($urandom);
    chk("in_ready_busy", 32'(ir[d]), 32'd0);
    lat = 1;
    while (!ov[d] && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", 32'(ov[d]), 32'd1);
    if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      chk("hold_sum", 32'(sm[d]), 32'(sbq[0].s));
      chk("hold_cout", 32'(co[d]), 32'(sbq[0].c));
      chk("hold_in_ready", 32'(ir[d]), 32'd0);
      iv[d] = 1'($urandom); av[d] = 16'($urandom); bv[d] = 16'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 32'(ov[d]), 32'd1);
    end
    iv[d] = 1'b0;
    ors[d] = 1'b1;
    e = sbq.pop_front();
    chk("sum", 32'(sm[d]), 32'(e.s));
    chk("cout", 32'(co[d]), 32'(e.c));
    chk("ovf", 32'(of[d]), 32'(e.o));
    @(negedge clk);
    ors[d] = 1'b0;
    chk("out_valid_after", 32'(ov[d]), 32'd0);
    chk("in_ready_after", 32'(ir[d]), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 5; d++) begin
      iv[d] = 1'b0; ors[d] = 1'b0; ci[d] = 1'b0; sb[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 5; d++) begin
      chk("rst_in_ready", 32'(ir[d]), 32'd1);
      chk("rst_out_valid", 32'(ov[d]), 32'd0);
      chk("rst_sum", 32'(sm[d]), 32'd0);
      chk("rst_cout", 32'(co[d]), 32'd0);
      chk("rst_ovf", 32'(of[d]), 32'd0);
    end

    // Exhaustive 1-bit add
    for (int k = 0; k < 8; k++)
      txn(0, 16'(k[2]), 16'(k[1]), k[0], 1'b0, 2, 0, 0);

    // 8-bit ripple, carry out of the top
    txn(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 9, 0, 0);

    // 8-bit, 4-bit chunks, subtraction with and without signed overflow
    txn(2, 16'h0080, 16'h0001, 1'b0, 1'b1, 3, 0, 0);
    txn(2, 16'h0003, 16'h0005, 1'b0, 1'b1, 3, 0, 0);

    // Single-chunk configuration
    txn(4, 16'h007F, 16'h0001, 1'b0, 1'b0, 2, 0, 0);
    txn(4, 16'h00C0, 16'h0041, 1'b1, 1'b0, 2, 0, 0);

    // Back-pressure with input noise while the result is held
    txn(1, 16'h005A, 16'h00C3, 1'b1, 1'b0, 9, 5, 0);

    // Reset in the middle of a BUSY run
    @(negedge clk);
    av[1] = 16'h00AA; bv[1] = 16'h0055; ci[1] = 1'b0; sb[1] = 1'b0; iv[1] = 1'b1;
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov[1]), 32'd0);
    chk("midrst_sum", 32'(sm[1]), 32'd0);
    chk("midrst_cout", 32'(co[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(ov[1]), 32'd0);
    end
    txn(1, 16'h0012, 16'h0034, 1'b0, 1'b0, 9, 0, 0);

    // Random operands, modes and stalls at 16 bits / 4-bit chunks
    for (int i = 0; i < 1000; i++)
      txn(3, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 5,
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
